// File: rtl/mdu_controller.sv
// HI/LO multiply/divide sequencing controller for the E stage: busy countdown, pending result, commit.
// Optional MDU_DIVZERO_HOLD_EN: a divide with a zero divisor is refused instead of started.
module mdu_controller #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic        stall_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MUL_RUN = 2'd1;
  localparam logic [1:0] DIV_RUN = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] p_hi, p_lo;

  logic        is_mul, is_div, div_zero, div_ok, start;
  logic [63:0] prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;

  assign is_mul   = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
  assign is_div   = (e_md_op == OP_DIV)  || (e_md_op == OP_DIVU);
  assign div_zero = (e_rt == 32'd0);

`ifdef MDU_DIVZERO_HOLD_EN
  assign div_ok = ~div_zero;
`else
  assign div_ok = 1'b1;
`endif

  assign start    = e_valid && (state == IDLE) && (is_mul || (is_div && div_ok));
  assign busy     = (state != IDLE);
  assign stall_md = d_is_md && (busy || start);

  // Signed product taken as the low 64 bits of the sign-extended operands' product.
  assign prod = (e_md_op == OP_MULT) ? ({{32{e_rs[31]}}, e_rs} * {{32{e_rt[31]}}, e_rt})
                                     : ({32'd0, e_rs} * {32'd0, e_rt});

  // Signed divide via magnitudes; INT_MIN / -1 falls out as 0x80000000 rem 0.
  assign neg_a = (e_md_op == OP_DIV) && e_rs[31];
  assign neg_b = (e_md_op == OP_DIV) && e_rt[31];
  assign mag_a = neg_a ? (~e_rs + 32'd1) : e_rs;
  assign mag_b = neg_b ? (~e_rt + 32'd1) : e_rt;
  assign q_mag = div_zero ? 32'd0 : (mag_a / mag_b);
  assign r_mag = div_zero ? 32'd0 : (mag_a % mag_b);
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              state <= MUL_RUN;
              cnt   <= 4'(MUL_LAT);
              p_hi  <= prod[63:32];
              p_lo  <= prod[31:0];
            end else begin
              state <= DIV_RUN;
              cnt   <= 4'(DIV_LAT);
              p_hi  <= div_zero ? e_rs : rem;
              p_lo  <= div_zero ? 32'hFFFF_FFFF : quo;
            end
          end else if (e_valid && (e_md_op == OP_MTHI)) begin
            hi <= e_rs;
          end else if (e_valid && (e_md_op == OP_MTLO)) begin
            lo <= e_rs;
          end
        end
        MUL_RUN, DIV_RUN: begin
          // Any MD op arriving here is a protocol violation and is dropped.
          if (cnt == 4'd1) begin
            hi    <= p_hi;
            lo    <= p_lo;
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    md_rdata = 32'd0;
    case (e_md_op)
      OP_MFHI: md_rdata = hi;
      OP_MFLO: md_rdata = lo;
      default: md_rdata = 32'd0;
    endcase
  end

endmodule
